// File: rtl/banco_registros_pkg.sv
// Shared definitions for the parameterised register bank: clear-engine states
// and default parameter values.
package banco_registros_pkg;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    LIMPIANDO = 2'd1,
    FIN       = 2'd2
  } estado_t;

  localparam int unsigned ANCHO_DEF       = 16;
  localparam int unsigned PROFUNDIDAD_DEF = 8;
  localparam int unsigned PUERTOS_DEF     = 2;
  localparam int unsigned CERO_FIJO_DEF   = 0;

endpackage

// File: rtl/banco_registros_if.sv
// Write/read/clear bus of the register bank; master drives requests, slave answers.
interface banco_registros_if
  import banco_registros_pkg::*;
#(
  parameter int unsigned ANCHO   = ANCHO_DEF,
  parameter int unsigned AW      = $clog2(PROFUNDIDAD_DEF),
  parameter int unsigned PUERTOS = PUERTOS_DEF
);
  logic                       Habilitar;
  logic [AW-1:0]              DireccionEscritura;
  logic [ANCHO-1:0]           Tupla;
  logic [PUERTOS*AW-1:0]      DireccionLectura;
  logic [PUERTOS*ANCHO-1:0]   Rta;
  logic                       Limpiar;
  logic                       Ocupado;
  logic                       Listo;

  modport master (
    output Habilitar, DireccionEscritura, Tupla, DireccionLectura, Limpiar,
    input  Rta, Ocupado, Listo
  );

  modport slave (
    input  Habilitar, DireccionEscritura, Tupla, DireccionLectura, Limpiar,
    output Rta, Ocupado, Listo
  );
endinterface

// File: rtl/banco_limpiador.sv
// Sequential clear engine: walks every register index once, one per cycle,
// then pulses Listo for a single cycle.
module banco_limpiador
  import banco_registros_pkg::*;
#(
  parameter int unsigned PROFUNDIDAD = PROFUNDIDAD_DEF,
  localparam int unsigned AW = $clog2(PROFUNDIDAD)
) (
  input  logic          Reloj,
  input  logic          ReiniciarN,
  input  logic          Limpiar,
  output logic          Ocupado,
  output logic          Listo,
  output logic [AW-1:0] indice,
  output logic          borrar
);

  estado_t       estado, estado_sig;
  logic [AW-1:0] contador, contador_sig;

  always_ff @(posedge Reloj) begin
    if (!ReiniciarN) begin
      estado   <= INACTIVO;
      contador <= '0;
    end else begin
      estado   <= estado_sig;
      contador <= contador_sig;
    end
  end

  // Exit is decided on the last index so the counter never re-enters by wrapping.
  always_comb begin
    estado_sig   = estado;
    contador_sig = contador;
    case (estado)
      INACTIVO: begin
        if (Limpiar) begin
          estado_sig   = LIMPIANDO;
          contador_sig = '0;
        end
      end
      LIMPIANDO: begin
        contador_sig = AW'(contador + 1'b1);
        if (contador == AW'(PROFUNDIDAD - 1)) estado_sig = FIN;
      end
      FIN:     estado_sig = INACTIVO;
      default: estado_sig = INACTIVO;
    endcase
  end

  always_comb begin
    Ocupado = 1'b0;
    Listo   = 1'b0;
    borrar  = 1'b0;
    indice  = contador;
    case (estado)
      LIMPIANDO: begin
        Ocupado = 1'b1;
        borrar  = 1'b1;
      end
      FIN:     Listo = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/banco_registros_param.sv
// Multi-port register bank with write-to-read bypass, optional hard-wired
// zero register and a sequential clear engine.
module banco_registros_param
  import banco_registros_pkg::*;
#(
  parameter int unsigned ANCHO       = ANCHO_DEF,
  parameter int unsigned PROFUNDIDAD = PROFUNDIDAD_DEF,
  parameter int unsigned PUERTOS     = PUERTOS_DEF,
  parameter int unsigned CERO_FIJO   = CERO_FIJO_DEF
) (
  input logic               Reloj,
  input logic               ReiniciarN,
  banco_registros_if.slave  bus
);

  localparam int unsigned AW = $clog2(PROFUNDIDAD);

  logic [ANCHO-1:0] mem [PROFUNDIDAD];
  logic             ocupado;
  logic             listo;
  logic             borrar;
  logic [AW-1:0]    indice;
  logic             escribir;

  banco_limpiador #(.PROFUNDIDAD(PROFUNDIDAD)) u_limpiador (
    .Reloj      (Reloj),
    .ReiniciarN (ReiniciarN),
    .Limpiar    (bus.Limpiar),
    .Ocupado    (ocupado),
    .Listo      (listo),
    .indice     (indice),
    .borrar     (borrar)
  );

  assign bus.Ocupado = ocupado;
  assign bus.Listo   = listo;

  // A write to the hard-wired zero register is dropped and never bypassed.
  assign escribir = bus.Habilitar && !ocupado &&
                    !((CERO_FIJO != 0) && (bus.DireccionEscritura == AW'(0)));

  always_ff @(posedge Reloj) begin
    if (!ReiniciarN) begin
      for (int i = 0; i < int'(PROFUNDIDAD); i++) mem[i] <= '0;
    end else if (borrar) begin
      mem[indice] <= '0;
    end else if (escribir) begin
      mem[bus.DireccionEscritura] <= bus.Tupla;
    end
  end

  for (genvar p = 0; p < int'(PUERTOS); p++) begin : g_puerto
    logic [AW-1:0]    dir;
    logic [ANCHO-1:0] dato;

    assign dir = bus.DireccionLectura[p*AW +: AW];

    always_comb begin
      dato = mem[dir];
      if ((CERO_FIJO != 0) && (dir == AW'(0))) begin
        dato = '0;
      end else if (escribir && (dir == bus.DireccionEscritura)) begin
        dato = bus.Tupla;
      end
    end

    assign bus.Rta[p*ANCHO +: ANCHO] = dato;
  end

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: default bank plus a 16-deep,
// 3-port bank with a hard-wired zero register.
module tb_banco_registros_param;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;

  banco_registros_if #(.ANCHO(16), .AW(3), .PUERTOS(2)) ifa ();
  banco_registros_if #(.ANCHO(16), .AW(4), .PUERTOS(3)) ifb ();

  banco_registros_param u_dut_a (
    .Reloj      (clk),
    .ReiniciarN (rst_n),
    .bus        (ifa)
  );

  banco_registros_param #(
    .ANCHO(16), .PROFUNDIDAD(16), .PUERTOS(3), .CERO_FIJO(1)
  ) u_dut_b (
    .Reloj      (clk),
    .ReiniciarN (rst_n),
    .bus        (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.Habilitar = 1'b0; ifa.DireccionEscritura = '0; ifa.Tupla = '0;
    ifa.DireccionLectura = '0; ifa.Limpiar = 1'b0;
    ifb.Habilitar = 1'b0; ifb.DireccionEscritura = '0; ifb.Tupla = '0;
    ifb.DireccionLectura = '0; ifb.Limpiar = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    ifa.DireccionLectura = 6'o47;
    #1;
    check("reset_rta", 64'(ifa.Rta), 64'h0);
    check("reset_ocupado", 64'(ifa.Ocupado), 64'h0);
    check("reset_listo", 64'(ifa.Listo), 64'h0);

    // Basic writes: reg7=3, reg4=5; port0 reads 7, port1 reads 4
    ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'd7; ifa.Tupla = 16'h0003;
    step();
    ifa.Habilitar = 1'b0;
    #1;
    check("write_r7", 64'(ifa.Rta), 64'h0000_0003);
    ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'd4; ifa.Tupla = 16'h0005;
    step();
    ifa.Habilitar = 1'b0;
    #1;
    check("write_r4", 64'(ifa.Rta), 64'h0005_0003);

    // Bypass on both ports, then stored value after the edge
    ifa.DireccionLectura = 6'o77;
    ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'd7; ifa.Tupla = 16'h00AA;
    #1;
    check("bypass_dual", 64'(ifa.Rta), 64'h00AA_00AA);
    step();
    ifa.Habilitar = 1'b0;
    #1;
    check("stored_dual", 64'(ifa.Rta), 64'h00AA_00AA);

    // Fill all registers with 0x1111
    for (int i = 0; i < 8; i++) begin
      ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'(i); ifa.Tupla = 16'h1111;
      step();
    end
    ifa.Habilitar = 1'b0;
    ifa.DireccionLectura = 6'o02;
    #1;
    check("fill", 64'(ifa.Rta), 64'h1111_1111);

    // Clear with simultaneous write of 0xBEEF to reg 2 at edge k
    ifa.Limpiar = 1'b1;
    ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'd2; ifa.Tupla = 16'hBEEF;
    step();
    ifa.Limpiar = 1'b0;
    ifa.Habilitar = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      check("clr_ocupado", 64'(ifa.Ocupado), 64'h1);
      check("clr_listo_low", 64'(ifa.Listo), 64'h0);
      if (c == 1) check("clr_same_edge_write", 64'(ifa.Rta[15:0]), 64'hBEEF);
      if (c == 5) begin
        ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'd0; ifa.Tupla = 16'h7777;
        #1;
        check("clr_no_bypass", 64'(ifa.Rta), 64'h0000_0000);
      end
      step();
      ifa.Habilitar = 1'b0;
    end
    #1;
    check("fin_ocupado", 64'(ifa.Ocupado), 64'h0);
    check("fin_listo", 64'(ifa.Listo), 64'h1);
    step();
    check("idle_listo", 64'(ifa.Listo), 64'h0);
    check("clr_r0_r2", 64'(ifa.Rta), 64'h0000_0000);
    ifa.DireccionLectura = 6'o67;
    #1;
    check("clr_r6_r7", 64'(ifa.Rta), 64'h0000_0000);

    // Reset aborts a clear at edge k+4
    ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'd3; ifa.Tupla = 16'h1234;
    step();
    ifa.DireccionEscritura = 3'd6; ifa.Tupla = 16'h5678;
    step();
    ifa.Habilitar = 1'b0;
    ifa.DireccionLectura = 6'o63;
    #1;
    check("pre_abort", 64'(ifa.Rta), 64'h5678_1234);
    ifa.Limpiar = 1'b1;
    step();
    ifa.Limpiar = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    ifa.Habilitar = 1'b1; ifa.DireccionEscritura = 3'd6; ifa.Tupla = 16'h9999;
    step();
    rst_n = 1'b1;
    ifa.Habilitar = 1'b0;
    #1;
    check("abort_rta", 64'(ifa.Rta), 64'h0);
    check("abort_ocupado", 64'(ifa.Ocupado), 64'h0);
    check("abort_listo", 64'(ifa.Listo), 64'h0);
    step();
    check("abort_no_listo", 64'(ifa.Listo), 64'h0);

    // Fresh clear after abort lasts exactly 8 cycles
    ifa.Limpiar = 1'b1;
    step();
    ifa.Limpiar = 1'b0;
    n = 0;
    while (ifa.Ocupado && n < 20) begin
      n++;
      step();
    end
    check("restart_len", 64'(n), 64'd8);
    check("restart_listo", 64'(ifa.Listo), 64'h1);

    // Hard-wired zero bank: 16 deep, 3 ports, reads 0/15/15
    ifb.Habilitar = 1'b1; ifb.DireccionEscritura = 4'd0; ifb.Tupla = 16'hFFFF;
    step();
    ifb.DireccionEscritura = 4'd15; ifb.Tupla = 16'h1234;
    step();
    ifb.Habilitar = 1'b0;
    ifb.DireccionLectura = 12'hFF0;
    #1;
    check("zero_reads", 64'(ifb.Rta), 64'h1234_1234_0000);
    ifb.Habilitar = 1'b1; ifb.DireccionEscritura = 4'd0; ifb.Tupla = 16'hABCD;
    #1;
    check("zero_bypass", 64'(ifb.Rta), 64'h1234_1234_0000);
    ifb.DireccionEscritura = 4'd15; ifb.Tupla = 16'h4321;
    #1;
    check("b_bypass_r15", 64'(ifb.Rta), 64'h4321_4321_0000);
    step();
    ifb.Habilitar = 1'b0;
    #1;
    check("b_stored_r15", 64'(ifb.Rta), 64'h4321_4321_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
